usermem_io: RTL and testbench

USERMEM_IO -- requirements
Module: usermem_io

---
 rtl/usermem_io_pkg.sv | 32 +++
 rtl/usermem_io_if.sv | 20 ++
 rtl/usermem_timer.sv | 117 +++++++++++
 rtl/usermem_io.sv | 85 ++++++++
 tb/tb_usermem_io.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/usermem_io_pkg.sv
// ---------------------------------------------------------------------------
// usermem_io_pkg
// Shared definitions for the user memory / IO block: register addresses of
// the peripheral window at the top of the byte address space, the last RAM
// address, and the CTRL register layout.
// No ports (package).
// ---------------------------------------------------------------------------
package usermem_io_pkg;

    localparam logic [7:0] ADDR_GPIO_OUT = 8'hF0;
    localparam logic [7:0] ADDR_GPIO_IN  = 8'hF1;
    localparam logic [7:0] ADDR_RELOAD   = 8'hF2;
    localparam logic [7:0] ADDR_COUNT    = 8'hF3;
    localparam logic [7:0] ADDR_CTRL     = 8'hF4;
    localparam logic [7:0] ADDR_STATUS   = 8'hF5;
    localparam logic [7:0] ADDR_PRESCALE = 8'hF6;

    localparam logic [7:0] RAM_TOP   = 8'hEF;
    localparam int         RAM_DEPTH = 240;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_IE   = 1;
    localparam int CTRL_AUTO = 2;

    // Field order matches the CTRL bit indices above (en is bit 0).
    typedef struct packed {
        logic auto_rl;
        logic ie;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/usermem_io_if.sv
// ---------------------------------------------------------------------------
// usermem_io_if
// CPU-side bus of the user memory / IO block.
//   rw     : 1 = write wdata to addr on the rising edge, 0 = read
//   addr   : byte address
//   wdata  : write data
//   rdata  : combinational read data for addr
//   irq    : single-cycle timer interrupt pulse
// master = CPU, slave = usermem_io.
// ---------------------------------------------------------------------------
interface usermem_io_if;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       irq;

    modport master (output rw, addr, wdata, input  rdata, irq);
    modport slave  (input  rw, addr, wdata, output rdata, irq);
endinterface

// File: rtl/usermem_timer.sv
// ---------------------------------------------------------------------------
// usermem_timer
// Prescaled down-counter with expiry flag and interrupt pulse. Owns the
// RELOAD, CTRL, STATUS and PRESCALE registers because the timer itself
// modifies CTRL.EN and STATUS[0].
//   clk, reset          : clock, synchronous active-high reset
//   wr_i, addr_i, wdata_i : CPU write strobe, address and data
//   reload_o, count_o, prescale_o, status_o, ctrl_o : register read values
//   irq_o               : one-cycle interrupt pulse
// ---------------------------------------------------------------------------
module usermem_timer
    import usermem_io_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] reload_o,
    output logic [7:0] count_o,
    output logic [7:0] prescale_o,
    output logic [7:0] status_o,
    output logic [7:0] ctrl_o,
    output logic       irq_o
);

    logic [7:0] reload_q,   reload_d;
    logic [7:0] prescale_q, prescale_d;
    logic [7:0] count_q,    count_d;
    logic [7:0] pre_q,      pre_d;
    ctrl_t      ctrl_q,     ctrl_d;
    logic       status_q,   status_d;
    logic       irq_q,      irq_d;

    logic wr_reload, wr_prescale, wr_ctrl, wr_status;
    logic tick, expiry, en_rise;

    always_comb begin
        wr_reload   = wr_i && (addr_i == ADDR_RELOAD);
        wr_prescale = wr_i && (addr_i == ADDR_PRESCALE);
        wr_ctrl     = wr_i && (addr_i == ADDR_CTRL);
        wr_status   = wr_i && (addr_i == ADDR_STATUS);
        en_rise     = wr_ctrl && wdata_i[CTRL_EN] && !ctrl_q.en;
        // Equality compare: a prescaler already past a newly lowered PRESCALE
        // runs on to 0xFF and wraps naturally before the next tick.
        tick        = ctrl_q.en && (pre_q == prescale_q);
        expiry      = tick && (count_q == 8'h00);
    end

    // NOTE: every next-state variable gets its hold value first so that no
    // path through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        reload_d   = reload_q;
        prescale_d = prescale_q;
        count_d    = count_q;
        pre_d      = pre_q;
        ctrl_d     = ctrl_q;
        status_d   = status_q;
        // Gated by irq_q so back-to-back expiries never hold irq high.
        irq_d      = expiry && ctrl_q.ie && !irq_q;

        if (wr_reload)              reload_d   = wdata_i;
        if (wr_prescale)            prescale_d = wdata_i;
        if (wr_ctrl)                ctrl_d     = ctrl_t'(wdata_i[2:0]);
        if (wr_status && wdata_i[0]) status_d  = 1'b0;

        if (ctrl_q.en) pre_d = tick ? 8'h00 : pre_q + 8'd1;

        if (tick) begin
            if (!expiry) begin
                count_d = count_q - 8'd1;
            end else begin
                // Applied after the CPU writes: expiry beats W1C and a
                // concurrent CTRL write cannot keep a one-shot timer running.
                status_d = 1'b1;
                if (ctrl_q.auto_rl) count_d   = reload_q;
                else                ctrl_d.en = 1'b0;
            end
        end

        // Only possible while EN=0, so it never collides with a tick.
        if (en_rise) begin
            count_d = reload_q;
            pre_d   = 8'h00;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            reload_q   <= 8'h00;
            prescale_q <= 8'h00;
            count_q    <= 8'h00;
            pre_q      <= 8'h00;
            ctrl_q     <= '0;
            status_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            reload_q   <= reload_d;
            prescale_q <= prescale_d;
            count_q    <= count_d;
            pre_q      <= pre_d;
            ctrl_q     <= ctrl_d;
            status_q   <= status_d;
            irq_q      <= irq_d;
        end
    end

    assign reload_o   = reload_q;
    assign count_o    = count_q;
    assign prescale_o = prescale_q;
    assign status_o   = {7'b0, status_q};
    assign ctrl_o     = {5'b0, ctrl_q};
    assign irq_o      = irq_q;

endmodule

// File: rtl/usermem_io.sv
// ---------------------------------------------------------------------------
// usermem_io
// 240-byte RAM plus memory-mapped GPIO and timer registers on a single-cycle
// CPU bus. Reads are combinational, writes happen on every edge with rw=1.
//   clk, reset : clock, synchronous active-high reset
//   bus        : CPU bus (usermem_io_if.slave)
//   gpio_in    : external inputs, asynchronous to clk
//   gpio_out   : registered GPIO output
// ---------------------------------------------------------------------------
module usermem_io
    import usermem_io_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    usermem_io_if.slave  bus,
    input  logic [7:0]   gpio_in,
    output logic [7:0]   gpio_out
);

    logic [7:0] ram_q [RAM_DEPTH];
    logic [7:0] gpio_out_q, gpio_out_d;
    logic [7:0] sync1_q, sync2_q;

    logic [7:0] reload, count, prescale, status, ctrl;
    logic       irq;

    // NOTE: the RAM array is deliberately left out of reset so it maps onto
    // plain memory; its contents survive a reset.
    always_ff @(posedge clk) begin
        if (bus.rw && (bus.addr <= RAM_TOP)) ram_q[bus.addr] <= bus.wdata;
    end

    always_comb begin
        gpio_out_d = gpio_out_q;
        if (bus.rw && (bus.addr == ADDR_GPIO_OUT)) gpio_out_d = bus.wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out_q <= 8'h00;
            sync1_q    <= 8'h00;
            sync2_q    <= 8'h00;
        end else begin
            gpio_out_q <= gpio_out_d;
            sync1_q    <= gpio_in;
            sync2_q    <= sync1_q;
        end
    end

    usermem_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .wr_i       (bus.rw),
        .addr_i     (bus.addr),
        .wdata_i    (bus.wdata),
        .reload_o   (reload),
        .count_o    (count),
        .prescale_o (prescale),
        .status_o   (status),
        .ctrl_o     (ctrl),
        .irq_o      (irq)
    );

    always_comb begin
        bus.rdata = 8'h00;
        if (bus.addr <= RAM_TOP) begin
            bus.rdata = ram_q[bus.addr];
        end else begin
            case (bus.addr)
                ADDR_GPIO_OUT: bus.rdata = gpio_out_q;
                ADDR_GPIO_IN:  bus.rdata = sync2_q;
                ADDR_RELOAD:   bus.rdata = reload;
                ADDR_COUNT:    bus.rdata = count;
                ADDR_CTRL:     bus.rdata = ctrl;
                ADDR_STATUS:   bus.rdata = status;
                ADDR_PRESCALE: bus.rdata = prescale;
                default:       bus.rdata = 8'h00;
            endcase
        end
    end

    assign bus.irq  = irq;
    assign gpio_out = gpio_out_q;

endmodule

// File: tb/tb_usermem_io.sv
// ---------------------------------------------------------------------------
// tb_usermem_io
// Self-checking bench for usermem_io: a table of bus vectors with expected
// read data fed through a scoreboard queue, plus hand-written sequences for
// the GPIO synchronizer, timer expiry/irq timing, W1C collision and reset.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_usermem_io;
    import usermem_io_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] gpio_in;
    logic [7:0] gpio_out;

    usermem_io_if bus ();

    usermem_io dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       chk;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one bus cycle on the falling edge; returns 1 ns later so the
    // caller can sample state left by the previous rising edge.
    task automatic cyc(input logic rw, input logic [7:0] addr, input logic [7:0] wdata);
        @(negedge clk);
        bus.rw    = rw;
        bus.addr  = addr;
        bus.wdata = wdata;
        #1;
    endtask

    function automatic void add_w(input logic [7:0] a, input logic [7:0] d);
        vecs.push_back('{rw: 1'b1, addr: a, wdata: d, chk: 1'b0, exp: 8'h00});
    endfunction

    function automatic void add_r(input logic [7:0] a, input logic [7:0] e);
        vecs.push_back('{rw: 1'b0, addr: a, wdata: 8'h00, chk: 1'b1, exp: e});
    endfunction

    // Reads COUNT for n cycles; k=0 is the sample right after the edge that
    // applies the preceding write. Records irq positions and COUNT at first irq.
    task automatic watch(input int n, output int first, output int second,
                         output int highs, output logic [7:0] cnt_first);
        first = -1; second = -1; highs = 0; cnt_first = 8'h00;
        for (int k = 0; k < n; k++) begin
            cyc(1'b0, ADDR_COUNT, 8'h00);
            if (bus.irq === 1'b1) begin
                highs++;
                if (first < 0) begin
                    first     = k;
                    cnt_first = bus.rdata;
                end else if (second < 0) begin
                    second = k;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         f, s, h;
        logic [7:0] c;
        logic [7:0] regs [5];

        reset     = 1'b1;
        gpio_in   = 8'h00;
        bus.rw    = 1'b0;
        bus.addr  = 8'h00;
        bus.wdata = 8'h00;
        cyc(1'b0, 8'h00, 8'h00);
        cyc(1'b0, 8'h00, 8'h00);
        reset = 1'b0;

        // ---- reset state ----
        check("reset irq", bus.irq, 1'b0);
        check("reset gpio_out", gpio_out, 8'h00);
        for (int a = 8'hF0; a <= 8'hF6; a++) begin
            cyc(1'b0, 8'(a), 8'h00);
            check($sformatf("reset reg 0x%0h", a), bus.rdata, 8'h00);
        end

        // ---- table-driven bus vectors ----
        add_w(8'h10, 8'h5A); add_r(8'h10, 8'h5A);
        add_r(8'hF8, 8'h00);
        add_w(8'hF8, 8'h77); add_r(8'hF8, 8'h00);   // reserved: write ignored
        add_w(8'hFF, 8'h11); add_r(8'hFF, 8'h00);
        add_w(8'hF0, 8'h81); add_r(8'hF0, 8'h81);
        add_w(8'hF2, 8'h37); add_w(8'hF2, 8'h37); add_r(8'hF2, 8'h37);
        add_w(8'hF3, 8'h55); add_r(8'hF3, 8'h00);   // COUNT is read-only
        add_w(8'hF1, 8'h99); add_r(8'hF1, 8'h00);   // GPIO_IN is read-only
        add_w(8'hF6, 8'h12); add_r(8'hF6, 8'h12);
        add_w(8'hF4, 8'hF8); add_r(8'hF4, 8'h00);   // CTRL[7:3] ignored
        add_w(8'hEF, 8'hA5); add_r(8'hEF, 8'hA5);   // last RAM byte
        add_w(8'h00, 8'h3C); add_r(8'h00, 8'h3C);
        add_r(8'h10, 8'h5A);

        foreach (vecs[i]) begin
            cyc(vecs[i].rw, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].chk) sb.push_back(vecs[i].exp);
            if (vecs[i].chk) begin
                if (sb.size() == 0) check($sformatf("vec%0d scoreboard empty", i), 1, 0);
                else check($sformatf("vec%0d rd 0x%0h", i, vecs[i].addr), bus.rdata, sb.pop_front());
            end
        end

        // ---- gpio_out is registered: visible one cycle after the write ----
        cyc(1'b1, ADDR_GPIO_OUT, 8'h24);
        cyc(1'b1, ADDR_GPIO_OUT, 8'h81);
        check("gpio_out after 0x24", gpio_out, 8'h24);
        cyc(1'b0, ADDR_GPIO_OUT, 8'h00);
        check("gpio_out after 0x81", gpio_out, 8'h81);

        // ---- gpio_in through the 2-flop synchronizer ----
        cyc(1'b0, ADDR_GPIO_IN, 8'h00);
        gpio_in = 8'hC3;
        cyc(1'b0, ADDR_GPIO_IN, 8'h00);
        check("gpio_in 1 cycle", bus.rdata, 8'h00);
        cyc(1'b0, ADDR_GPIO_IN, 8'h00);
        check("gpio_in 2 cycles", bus.rdata, 8'hC3);

        // ---- PRESCALE=0, RELOAD=3, AUTO: irq every 4 cycles ----
        cyc(1'b1, ADDR_PRESCALE, 8'h00);
        cyc(1'b1, ADDR_RELOAD, 8'h03);
        cyc(1'b1, ADDR_CTRL, 8'h07);
        watch(10, f, s, h, c);
        check("auto first irq", f, 4);
        check("auto count at irq", c, 8'h03);
        check("auto second irq", s, 8);
        check("auto irq high cycles", h, 2);
        cyc(1'b0, ADDR_STATUS, 8'h00);
        check("auto status", bus.rdata, 8'h01);
        cyc(1'b1, ADDR_CTRL, 8'h00);
        cyc(1'b1, ADDR_STATUS, 8'h01);
        cyc(1'b0, ADDR_STATUS, 8'h00);
        check("status W1C", bus.rdata, 8'h00);

        // ---- PRESCALE=1, RELOAD=0: tick every second cycle ----
        cyc(1'b1, ADDR_PRESCALE, 8'h01);
        cyc(1'b1, ADDR_RELOAD, 8'h00);
        cyc(1'b1, ADDR_CTRL, 8'h07);
        watch(6, f, s, h, c);
        check("prescale first irq", f, 2);
        check("prescale second irq", s, 4);
        check("prescale irq high cycles", h, 2);
        cyc(1'b1, ADDR_CTRL, 8'h00);
        cyc(1'b0, ADDR_COUNT, 8'h00);
        cyc(1'b1, ADDR_STATUS, 8'h01);

        // ---- one-shot: AUTO=0, RELOAD=1, CTRL=0x03 ----
        cyc(1'b1, ADDR_PRESCALE, 8'h00);
        cyc(1'b1, ADDR_RELOAD, 8'h01);
        cyc(1'b1, ADDR_CTRL, 8'h03);
        watch(10, f, s, h, c);
        check("oneshot first irq", f, 2);
        check("oneshot irq count", h, 1);
        cyc(1'b0, ADDR_CTRL, 8'h00);
        check("oneshot ctrl EN cleared", bus.rdata, 8'h02);
        cyc(1'b0, ADDR_COUNT, 8'h00);
        check("oneshot count held", bus.rdata, 8'h00);

        // ---- W1C on the same edge as an expiry: set wins ----
        cyc(1'b1, ADDR_STATUS, 8'h01);
        cyc(1'b1, ADDR_CTRL, 8'h07);              // edge E0: COUNT <- 1
        cyc(1'b0, ADDR_COUNT, 8'h00);             // edge E1: COUNT -> 0
        cyc(1'b1, ADDR_STATUS, 8'h01);            // applied at E2 = expiry
        cyc(1'b0, ADDR_STATUS, 8'h00);
        check("status set beats W1C", bus.rdata, 8'h01);
        cyc(1'b1, ADDR_CTRL, 8'h00);
        cyc(1'b1, ADDR_STATUS, 8'h01);
        cyc(1'b1, ADDR_RELOAD, 8'h00);

        // ---- reset mid-count with COUNT=2 ----
        cyc(1'b1, ADDR_PRESCALE, 8'h03);
        cyc(1'b1, ADDR_RELOAD, 8'h02);
        cyc(1'b1, ADDR_CTRL, 8'h07);
        cyc(1'b0, ADDR_COUNT, 8'h00);
        check("pre-reset count", bus.rdata, 8'h02);
        cyc(1'b1, ADDR_GPIO_OUT, 8'hFF);          // write competing with reset
        reset = 1'b1;
        cyc(1'b0, ADDR_COUNT, 8'h00);
        check("reset count", bus.rdata, 8'h00);
        check("reset beats write gpio_out", gpio_out, 8'h00);
        check("reset irq low", bus.irq, 1'b0);
        reset = 1'b0;
        cyc(1'b0, ADDR_GPIO_IN, 8'h00);
        check("reset synchronizer", bus.rdata, 8'h00);
        gpio_in = 8'h00;
        regs = '{ADDR_GPIO_OUT, ADDR_RELOAD, ADDR_CTRL, ADDR_STATUS, ADDR_PRESCALE};
        foreach (regs[i]) begin
            cyc(1'b0, regs[i], 8'h00);
            check($sformatf("post-reset reg 0x%0h", regs[i]), bus.rdata, 8'h00);
        end
        watch(8, f, s, h, c);
        check("post-reset no irq", h, 0);
        check("post-reset count holds", bus.rdata, 8'h00);
        cyc(1'b0, 8'h10, 8'h00);
        check("RAM survives reset", bus.rdata, 8'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
